// File: rtl/conv_1k_row_fx.sv
// conv_1k_row_fx
//   Streaming 1xK row convolution over a W x H raster frame. Each row is
//   zero padded by P=(K-1)/2 pixels on both sides. Stride 1 or 2 is selected
//   once per frame. The signed fixed-point MAC saturates its result to DATA_W bits.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low
//   stride2    1 = emit even output columns only (sampled at first accept of a frame)
//   kernel     K taps, tap j at [j*DATA_W +: DATA_W] (latched at each row's col-0 accept)
//   valid_in   pxl_in is valid
//   pxl_in     input pixel, signed Q(DATA_W-FRAC_W).FRAC_W
//   in_ready   block can take a pixel this cycle
//   pxl_out    filtered pixel (holds its last value between outputs)
//   valid_out  one-cycle pulse per output pixel; downstream never stalls
//   eof_out    high together with the last output of the frame
//   state_dbg  current FSM state (0 = RUN, 1 = FLUSH)
//
// Handshake: a pixel is accepted on a rising edge where valid_in && in_ready.
// in_ready is low only while the right-edge padding is flushed. valid_in
// is ignored while in_ready is low. valid_in gaps simply hold all state.
module conv_1k_row_fx #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int K      = 3,
    parameter int W      = 299,
    parameter int H      = 299
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stride2,
    input  logic [K*DATA_W-1:0]   kernel,
    input  logic                  valid_in,
    input  logic [DATA_W-1:0]     pxl_in,
    output logic                  in_ready,
    output logic [DATA_W-1:0]     pxl_out,
    output logic                  valid_out,
    output logic                  eof_out,
    output logic                  state_dbg
);

    localparam int P     = (K - 1) / 2;
    localparam int CW    = $clog2(W);
    localparam int RW    = (H > 1) ? $clog2(H) : 1;
    localparam int FW    = $clog2(P + 1);
    localparam int SUM_W = 2 * DATA_W + $clog2(K);
    localparam logic W_EVEN = ((W % 2) == 0);

    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t                      state;
    logic [CW-1:0]               col;
    logic [RW-1:0]               row;
    logic [FW-1:0]               fcnt;
    logic                        stride_q;
    logic signed [DATA_W-1:0]    kern_q [K];
    logic signed [DATA_W-1:0]    win    [K];   // win[K-1] is the newest pixel
    logic signed [2*DATA_W-1:0]  prod   [K];
    logic                        s0_v, s0_eof, s1_v, s1_eof;

    logic                        accept, first_acc, stride_eff;
    logic                        trig, emit, eof_trig;
    logic [CW-1:0]               trig_c, last_c;
    logic [RW-1:0]               next_row;
    logic signed [SUM_W-1:0]     sum, shifted;
    logic [DATA_W-1:0]           sat_res;

    assign in_ready  = (state == RUN);
    assign state_dbg = state;
    assign accept    = valid_in && in_ready;
    // stride2 is taken from the port on the frame's first accept and frozen after.
    assign first_acc  = accept && (col == '0) && (row == '0);
    assign stride_eff = first_acc ? stride2 : stride_q;
    assign next_row   = (row == RW'(H - 1)) ? '0 : row + 1'b1;
    assign last_c     = (stride_eff && W_EVEN) ? CW'(W - 2) : CW'(W - 1);

    // Output column c is ready once pixel c+P is in the window (RUN), or
    // when a padding zero stands in for it (FLUSH).
    always_comb begin
        trig   = 1'b0;
        trig_c = '0;
        if (state == RUN) begin
            if (accept && (col >= CW'(P))) begin
                trig   = 1'b1;
                trig_c = col - CW'(P);
            end
        end else begin
            trig   = 1'b1;
            trig_c = CW'(W - P) + CW'(fcnt);
        end
    end

    assign emit     = trig && !(stride_eff && trig_c[0]);
    assign eof_trig = emit && (row == RW'(H - 1)) && (trig_c == last_c);

    always_comb begin
        sum = '0;
        for (int j = 0; j < K; j++) begin
            sum = sum + SUM_W'(prod[j]);
        end
    end

    // Arithmetic shift truncates toward -inf, then clamp to the output range.
    assign shifted = sum >>> FRAC_W;
    always_comb begin
        sat_res = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_res = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_res = SAT_MIN[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            col       <= '0;
            row       <= '0;
            fcnt      <= '0;
            stride_q  <= 1'b0;
            s0_v      <= 1'b0;
            s0_eof    <= 1'b0;
            s1_v      <= 1'b0;
            s1_eof    <= 1'b0;
            pxl_out   <= '0;
            valid_out <= 1'b0;
            eof_out   <= 1'b0;
            for (int j = 0; j < K; j++) begin
                win[j]    <= '0;
                kern_q[j] <= '0;
                prod[j]   <= '0;
            end
        end else begin
            if (first_acc) begin
                stride_q <= stride2;
            end

            case (state)
                RUN: begin
                    if (accept) begin
                        if (col == '0) begin
                            // New row: clear the window so nothing bleeds across rows.
                            for (int j = 0; j < K; j++) begin
                                win[j]    <= '0;
                                kern_q[j] <= kernel[j*DATA_W +: DATA_W];
                            end
                        end else begin
                            for (int j = 0; j < K - 1; j++) begin
                                win[j] <= win[j+1];
                            end
                        end
                        win[K-1] <= pxl_in;
                        if (col == CW'(W - 1)) begin
                            col   <= '0;
                            state <= FLUSH;
                            fcnt  <= '0;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    for (int j = 0; j < K - 1; j++) begin
                        win[j] <= win[j+1];
                    end
                    win[K-1] <= '0;
                    if (fcnt == FW'(P - 1)) begin
                        state <= RUN;
                        row   <= next_row;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase

            // Stage 0 flags travel with the window, stage 1 with the products.
            s0_v   <= emit;
            s0_eof <= eof_trig;
            for (int j = 0; j < K; j++) begin
                prod[j] <= (2*DATA_W)'(kern_q[j]) * (2*DATA_W)'(win[j]);
            end
            s1_v   <= s0_v;
            s1_eof <= s0_eof;

            valid_out <= s1_v;
            eof_out   <= s1_eof;
            if (s1_v) begin
                pxl_out <= sat_res;
            end
        end
    end

endmodule
